jtdsp16_prog_loader: RTL
========================

// Module: jtdsp16_prog_loader
// PURPOSE
//  Sequences download of the DSP16 program memory from an external word source
//  (SDRAM/ROM bridge) via req/ack handshake, drives prog_addr/prog_data/prog_we
//  into jtdsp16 and holds the core in reset during load plus a stretch period.
//  Sits between the system memory arbiter and jtdsp16. Replaces the ad-hoc
//  rst=prog_we tie-off.
// PARAMETERS
//  AW       12    program address width (words)
//  LEN      512   words to load; count range 1..2**AW
//  HOLD     4     cen cycles dsp_rst stays high after last write
//  TOUT     255   cen cycles to wait for src_ack before error; 8-bit counter
// PORTS
//  clk       in   1      system clock
//  rst_n     in   1      asynchronous active-low reset
//  cen       in   1      clock enable; all state advances only when cen=1
//  start     in   1      pulse: begin/restart load (level ignored after 1st cycle)
//  src_req   out  1      request word at src_addr; held until ack
//  src_addr  out  AW     source word address
//  src_ack   in   1      src_data valid this cycle
//  src_data  in   16     source word
//  prog_addr out  AW     jtdsp16 program write address
//  prog_data out  16     jtdsp16 program write data
//  prog_we   out  1      program write strobe, one cen cycle per word
//  dsp_rst   out  1      reset to jtdsp16 (active high)
//  busy      out  1      load in progress (REQ/WRITE/HOLD)
//  done      out  1      load completed, core running
//  err       out  1      source timeout (or checksum mismatch, see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, dsp_rst=1, src_req=0, prog_we=0, busy=0, done=0, err=0,
//   src_addr=prog_addr=0, prog_data=0, word counter cnt=0.
//  FSM (transitions on clk when cen=1):
//   IDLE : dsp_rst=1. start -> REQ, cnt=0.
//   REQ  : src_req=1, src_addr=cnt. src_ack -> latch src_data, WRITE.
//          No ack for TOUT cen cycles -> ERR.
//   WRITE: prog_we=1 exactly one cen cycle, prog_addr=cnt, prog_data=latched.
//          cnt==LEN-1 -> HOLD; else cnt+1, REQ. Min 2 cen cycles per word.
//   HOLD : dsp_rst=1 for HOLD cen cycles, prog_we=0 -> RUN.
//   RUN  : dsp_rst=0, done=1. start -> REQ (reload, dsp_rst re-asserted same edge).
//   ERR  : err=1, dsp_rst=1, src_req=0. start -> REQ, err cleared.
//  src_ack outside REQ is ignored. src_ack with cen=0 is not sampled; source
//   must hold ack until a cen cycle (handshake is cen-qualified).
//  start during REQ/WRITE/HOLD ignored (no mid-load restart).
//  rst_n asserted mid-load: immediate async return to reset values; partial
//   program stays in memory but dsp_rst=1 guarantees it never runs.
//  cnt is AW+1 bits so LEN=2**AW terminates without wrap; prog_addr never
//   exceeds LEN-1.
//  busy = state in {REQ,WRITE,HOLD}; done and err mutually exclusive.
// CONFIGURATION
//  JTDSP16_LOADER_CHKSUM_EN defined: adds ports chk_exp in 16 and chk_sum out 16.
//   chk_sum = mod-2**16 sum of all written words, cleared on entry to REQ from
//   IDLE/RUN/ERR, updated on each WRITE. On HOLD exit: chk_sum==chk_exp -> RUN,
//   else ERR (dsp_rst stays 1).
//  Not defined: ports absent, HOLD always -> RUN.
// STRUCTURE
//  Package jtdsp16_loader_pkg: state enum (IDLE,REQ,WRITE,HOLD,RUN,ERR), 3-bit
//   encoding, default constants for LEN/HOLD/TOUT.
//  Sub-module jtdsp16_loader_tmr: cen-gated down-counter shared by timeout (REQ)
//   and hold stretch (HOLD); load/zero-flag interface.
// TESTING
//  1 LEN=512, ack 1 cycle after req, start pulse -> 512 prog_we pulses, addrs
//    0..511 in order, data matches source, dsp_rst falls HOLD=4 cen after last we.
//  2 Random ack delay 0..20 and cen toggling 50% -> same memory image, no we when
//    cen=0, src_addr stable while src_req high.
//  3 Withhold ack at word 100 -> err=1 after 255 cen cycles, dsp_rst=1, busy=0;
//    then start -> reload from addr 0, done=1.
//  4 rst_n low at word 300 -> all outputs reset values same cycle; start -> full load.
//  5 start while RUN -> dsp_rst=1 next edge, full reload, done returns; start
//    during REQ ignored.
//  6 CHKSUM_EN, source words all 0x0001, LEN=512: chk_exp=0x0200 -> RUN;
//    chk_exp=0x0201 -> ERR, dsp_rst=1.

Source files
------------

// File: rtl/jtdsp16_loader_pkg.sv
// Shared types and defaults for the DSP16 program loader.
// Six-state FSM encoding plus parameter defaults and the timer width.
package jtdsp16_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam int DEF_AW   = 12;
  localparam int DEF_LEN  = 512;
  localparam int DEF_HOLD = 4;
  localparam int DEF_TOUT = 255;
  localparam int TMR_W    = 8;

endpackage

// File: rtl/jtdsp16_loader_tmr.sv
// Cen-gated down-counter shared by the source timeout and the reset stretch.
// load has priority over counting; zero is a combinational view of the count.
module jtdsp16_loader_tmr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cen) begin
      if (load)
        cnt <= load_val;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/jtdsp16_prog_loader.sv
// Downloads LEN program words from a req/ack source into jtdsp16, holding the core in reset
// until HOLD cen cycles after the last write. Optional JTDSP16_LOADER_CHKSUM_EN adds checksum gating.
module jtdsp16_prog_loader
  import jtdsp16_loader_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int LEN  = DEF_LEN,
  parameter int HOLD = DEF_HOLD,
  parameter int TOUT = DEF_TOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  output logic          src_req,
  output logic [AW-1:0] src_addr,
  input  logic          src_ack,
  input  logic [15:0]   src_data,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic          prog_we,
  output logic          dsp_rst,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef JTDSP16_LOADER_CHKSUM_EN
  ,
  input  logic [15:0]   chk_exp,
  output logic [15:0]   chk_sum
`endif
);

  localparam logic [AW:0]      LAST    = (AW+1)'(LEN - 1);
  localparam logic [TMR_W-1:0] TOUT_LD = TMR_W'(TOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'((HOLD > 0) ? HOLD - 1 : 0);

  state_t             state;
  logic [AW:0]        cnt;
  logic               start_q;
  logic               start_p;
  logic               last_word;
  logic               tmr_load;
  logic               tmr_zero;
  logic [TMR_W-1:0]   tmr_val;

  // Only the first cen cycle of a start level counts as a request.
  assign start_p   = start & ~start_q;
  assign last_word = (cnt == LAST);

  // The timer is preloaded in every state that does not consume it, so the value
  // is ready on the edge that enters REQ or HOLD.
  always_comb begin
    tmr_load = !(state inside {ST_REQ, ST_HOLD});
    tmr_val  = (state == ST_WRITE && last_word) ? HOLD_LD : TOUT_LD;
  end

  jtdsp16_loader_tmr #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      start_q   <= 1'b0;
      src_req   <= 1'b0;
      src_addr  <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      dsp_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef JTDSP16_LOADER_CHKSUM_EN
      chk_sum   <= '0;
`endif
    end else if (cen) begin
      start_q <= start;
      case (state)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (start_p) begin
            state    <= ST_REQ;
            cnt      <= '0;
            src_req  <= 1'b1;
            src_addr <= '0;
            dsp_rst  <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef JTDSP16_LOADER_CHKSUM_EN
            chk_sum  <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (src_ack) begin
            state     <= ST_WRITE;
            src_req   <= 1'b0;
            prog_data <= src_data;
            prog_addr <= cnt[AW-1:0];
            prog_we   <= 1'b1;
          end else if (tmr_zero) begin
            state   <= ST_ERR;
            src_req <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
          end
        end
        ST_WRITE: begin
          prog_we <= 1'b0;
`ifdef JTDSP16_LOADER_CHKSUM_EN
          chk_sum <= chk_sum + prog_data;
`endif
          if (last_word) begin
            state <= ST_HOLD;
          end else begin
            state    <= ST_REQ;
            cnt      <= cnt + 1'b1;
            src_addr <= cnt[AW-1:0] + 1'b1;
            src_req  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            busy <= 1'b0;
`ifdef JTDSP16_LOADER_CHKSUM_EN
            if (chk_sum == chk_exp) begin
              state   <= ST_RUN;
              dsp_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
`else
            state   <= ST_RUN;
            dsp_rst <= 1'b0;
            done    <= 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
